// File: rtl/au_abs_seq.sv
// au_abs_seq
//   Multi-cycle two's-complement to sign-magnitude converter. A signed word is
//   captured, sign-extended into a shift register, then conditionally negated
//   DIGIT bits per cycle, LSB first, with a registered carry between digits.
//   The result is held in DONE until the downstream side takes it.
//
// Parameters
//   WIDTH      word length of a and z (>= 1)
//   DIGIT      bits processed per cycle (1 to WIDTH)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   input word valid
//   in_ready   block can accept input (IDLE only, low while rst is high)
//   a          two's-complement input word
//   out_valid  result valid (DONE)
//   out_ready  downstream accepts result
//   z          magnitude |a|, unsigned
//   sign       sign of a
//   is_min     a was the most negative value; z then reads 2^(WIDTH-1)

module au_abs_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             is_min
);

  localparam int NCYC = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int P    = NCYC * DIGIT;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  localparam logic [CW-1:0]    LAST_CNT = CW'(NCYC - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [P-1:0]    sr;
  logic [P-1:0]    sr_ext;
  logic [P-1:0]    sr_step;
  logic [DIGIT-1:0] digit_x;
  logic [DIGIT:0]  digit_sum;
  logic            carry;
  logic [CW-1:0]   cnt;

  // The shift register is padded up to a whole number of digits; the pad
  // bits are sign copies so the negation ripples through them harmlessly and
  // they are simply dropped when z is read.
  assign sr_ext = P'($signed(a));

  // One digit of the conditional negation: invert when negative, add the
  // carry that was seeded with the sign (the "+1" of ~a+1) at capture.
  assign digit_x   = sr[DIGIT-1:0] ^ {DIGIT{sign}};
  assign digit_sum = {1'b0, digit_x} + {{DIGIT{1'b0}}, carry};

  // The finished digit enters at the top so after NCYC steps the word is
  // back in its original bit positions.
  generate
    if (NCYC == 1) begin : g_single
      assign sr_step = digit_sum[DIGIT-1:0];
    end else begin : g_multi
      assign sr_step = {digit_sum[DIGIT-1:0], sr[P-1:DIGIT]};
    end
  endgenerate

  assign z = sr[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)          state_nxt = BUSY;
      BUSY: if (cnt == LAST_CNT)   state_nxt = DONE;
      DONE: if (out_ready)         state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes; in_ready is also masked by rst
  // so nothing upstream sees the block as ready while it is being cleared.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Datapath: capture in IDLE, one digit per BUSY cycle, hold otherwise so
  // the result stays put in DONE and lingers in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr     <= '0;
      sign   <= 1'b0;
      is_min <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr     <= sr_ext;
            sign   <= a[WIDTH-1];
            carry  <= a[WIDTH-1];
            is_min <= (a == MIN_VAL);
            cnt    <= '0;
          end
        end
        BUSY: begin
          sr    <= sr_step;
          carry <= digit_sum[DIGIT];
          cnt   <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
